muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative RV32M/RV64M multiply/divide unit. It replaces the combinational mul/div datapath in the EX stage and handles all eight M-extension ops plus the RV64 W-ops. It is parametrised in datapath width and bits retired per cycle. A valid/ready handshake lets the hazard unit stall EX while the unit is busy, and a kill input aborts an in-flight op on flush, exception or mret.

Parameters:
XLEN, 32, datapath width; 32 or 64.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per iteration; 1, 2 or 4, must divide 32.
TAG_W, 5, width of the destination-register tag carried with the op.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low
in_valid  input  1  op request
in_ready  output  1  unit can accept an op
op  input  3  M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
s_32  input  1  W-op (XLEN=64 only; tie 0 when XLEN=32)
rs1  input  XLEN  operand a (dividend / multiplicand)
rs2  input  XLEN  operand b (divisor / multiplier)
tag_in  input  TAG_W  rd tag
kill  input  1  abort current op
out_valid  output  1  result available
out_ready  input  1  consumer takes result
result  output  XLEN  result
tag_out  output  TAG_W  tag of the result

Behaviour:
- Reset (reset=0, async): state IDLE; in_ready=1; out_valid=0; result=0; tag_out=0; all internal registers cleared. A reset mid-operation discards the op.
- States: IDLE, CALC, DONE. in_ready=1 only in IDLE.
- IDLE: on in_valid && !kill at an edge, capture operands, op, s_32 and tag.
  - Go to DONE if a divide special case applies.
  - Otherwise go to CALC with counter = W/BITS_PER_CYCLE, where W = 32 if s_32 else XLEN.
- CALC: each edge retires BITS_PER_CYCLE bits and decrements counter. On the edge where counter becomes 0, go to DONE.
  - out_valid therefore rises exactly W/BITS_PER_CYCLE edges after the accept edge.
- DONE: out_valid=1; result and tag_out are stable. At an edge with out_ready=1, return to IDLE. Results are held indefinitely while out_ready=0.
- kill: takes priority over everything.
  - At any edge with kill=1 in CALC or DONE, the state goes to IDLE and out_valid is 0 in the next cycle.
  - kill with in_valid in IDLE suppresses acceptance.
- Operand handling: signed ops work on magnitudes and apply sign correction after the final iteration, with no extra cycle.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MUL returns the low W bits of the product; MULH* return the high W bits of the 2W-bit product.
- Divide special cases (complete in 1 edge, no CALC):
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → dividend.
  - Signed overflow (dividend = most-negative, divisor = −1): DIV → dividend; REM → 0.
- Sign rules: quotient truncates toward zero; remainder takes the sign of the dividend.
- W-ops (s_32=1, XLEN=64): only the low 32 bits of rs1/rs2 are used. The 32-bit result is sign-extended from bit 31 to XLEN, including DIVUW/REMUW.
  - MULH/MULHSU/MULHU with s_32=1 return 0 with normal latency.
- out_valid never asserts without a preceding accept; exactly one result per accepted, un-killed op.

Test Plan:
- XLEN=32, BPC=1: MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB; out_valid rises exactly 32 edges after accept; tag_out = tag_in (e.g. 5'd11).
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2.
- Special cases, each with out_valid after 1 edge:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure and abort:
  - Hold out_ready=0 for 10 cycles in DONE: result and out_valid stable, in_ready=0.
  - kill at CALC counter=17: IDLE next cycle, no out_valid.
  - reset low mid-CALC: outputs at reset values immediately; the next op completes correctly.
- XLEN=64, BPC=4:
  - DIVW rs1=0x00000001_80000000, rs2=2 → 0xFFFFFFFF_C0000000 after 8 edges.
  - DIVUW same operands → 0x00000000_40000000.
  - MUL 64-bit 0x1_00000000×3 → 0x3_00000000 after 16 edges.

Source files
------------

// File: rtl/muldiv_seq.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Multiplies by shift-and-add and divides by restoring division. Both work on
// operand magnitudes, and the sign is fixed up on the last iteration.
// Handshake: an op is accepted on an edge where in_valid && in_ready && !kill.
// A result is consumed on an edge where out_valid && out_ready. kill wins
// over both: it drops any in-flight or pending result and blocks acceptance.
module muldiv_seq #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             s_32,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CW = 8;
    localparam logic [XLEN-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_r;
    logic               w_r;
    logic               sign_q;    // negate product / quotient
    logic               sign_r;    // negate remainder
    logic [2*XLEN-1:0]  acc;       // product accumulator
    logic [2*XLEN-1:0]  mcand;     // multiplicand, shifts left
    logic [XLEN-1:0]    mplier;    // multiplier, shifts right
    logic [XLEN:0]      rem;       // partial remainder (one guard bit)
    logic [XLEN-1:0]    quo;       // dividend shifting out, quotient shifting in
    logic [XLEN-1:0]    dvsr;

    // Sign-extend bit 31 to XLEN when w is set.
    function automatic logic [XLEN-1:0] sext(input logic [XLEN-1:0] x, input logic w);
        logic signed [XLEN-1:0] t;
        t = $signed(x << (XLEN - 32));
        t = t >>> (XLEN - 32);
        return w ? $unsigned(t) : x;
    endfunction

    // Accept-side operand decode.
    logic              w_mode;
    logic [XLEN-1:0]   mask;
    logic [XLEN-1:0]   a_low, b_low, a_mag, b_mag, special_res;
    logic              sa, sb, a_msb, b_msb, a_neg, b_neg;
    logic              b_zero, b_m1, a_min, div_special;
    logic [CW-1:0]     cnt_init;

    // Decode the incoming op: magnitudes, sign flags and divide special cases.
    always_comb begin
        w_mode   = (XLEN == 64) && s_32;
        mask     = w_mode ? ~(ONES << 32) : ONES;
        a_low    = rs1 & mask;
        b_low    = rs2 & mask;
        sa       = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        sb       = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        a_msb    = w_mode ? rs1[31] : rs1[XLEN-1];
        b_msb    = w_mode ? rs2[31] : rs2[XLEN-1];
        a_neg    = sa && a_msb;
        b_neg    = sb && b_msb;
        a_mag    = a_neg ? ((-a_low) & mask) : a_low;
        b_mag    = b_neg ? ((-b_low) & mask) : b_low;
        b_zero   = (b_low == '0);
        b_m1     = (b_low == mask);
        a_min    = a_msb && ((a_low & (mask >> 1)) == '0);
        div_special = op[2] && (b_zero || (((op == 3'd4) || (op == 3'd6)) && a_min && b_m1));
        if (b_zero) begin
            special_res = op[1] ? sext(a_low, w_mode) : ONES;
        end else begin
            special_res = op[1] ? '0 : sext(a_low, w_mode);
        end
        cnt_init = w_mode ? CW'(32 / BITS_PER_CYCLE) : CW'(XLEN / BITS_PER_CYCLE);
    end

    // One iteration: BITS_PER_CYCLE steps of shift-add and restoring divide.
    logic [2*XLEN-1:0] acc_n, mcand_n;
    logic [XLEN-1:0]   mplier_n, quo_n;
    logic [XLEN:0]     rem_n;

    always_comb begin
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        rem_n    = rem;
        quo_n    = quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_n[0]) begin
                acc_n = acc_n + mcand_n;
            end
            mcand_n  = mcand_n << 1;
            mplier_n = mplier_n >> 1;
            rem_n    = {rem_n[XLEN-1:0], quo_n[XLEN-1]};
            quo_n    = quo_n << 1;
            if (rem_n >= {1'b0, dvsr}) begin
                rem_n    = rem_n - {1'b0, dvsr};
                quo_n[0] = 1'b1;
            end
        end
    end

    // Sign correction and result select, used on the final iteration.
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   q_s, r_lo, r_s, sel, final_res;

    always_comb begin
        prod_s = sign_q ? -acc_n : acc_n;
        q_s    = sign_q ? -quo_n : quo_n;
        r_lo   = rem_n[XLEN-1:0];
        r_s    = sign_r ? -r_lo : r_lo;
        case (op_r)
            3'd0:             sel = acc_n[XLEN-1:0];
            3'd1, 3'd2, 3'd3: sel = w_r ? '0 : prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       sel = q_s;
            default:          sel = r_s;
        endcase
        final_res = sext(sel, w_r);
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            tag_out   <= '0;
            cnt       <= '0;
            op_r      <= '0;
            w_r       <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            rem       <= '0;
            quo       <= '0;
            dvsr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !kill) begin
                        op_r     <= op;
                        w_r      <= w_mode;
                        tag_out  <= tag_in;
                        sign_q   <= a_neg ^ b_neg;
                        sign_r   <= a_neg;
                        acc      <= '0;
                        mcand    <= {{XLEN{1'b0}}, a_mag};
                        mplier   <= b_mag;
                        rem      <= '0;
                        quo      <= w_mode ? (a_mag << (XLEN - 32)) : a_mag;
                        dvsr     <= b_mag;
                        in_ready <= 1'b0;
                        if (div_special) begin
                            result    <= special_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt   <= cnt_init;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (kill) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                    end else begin
                        acc    <= acc_n;
                        mcand  <= mcand_n;
                        mplier <= mplier_n;
                        rem    <= rem_n;
                        quo    <= quo_n;
                        cnt    <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            result    <= final_res;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (kill || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: a 32-bit/1-bit-per-cycle instance and a
// 64-bit/4-bit-per-cycle instance share one clock and reset.
module tb_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        in_valid32 = 1'b0, in_ready32, kill32 = 1'b0, out_valid32, out_ready32 = 1'b0;
    logic [2:0]  op32 = '0;
    logic        s_32_32 = 1'b0;
    logic [31:0] rs1_32 = '0, rs2_32 = '0, result32;
    logic [4:0]  tag32 = '0, tag_out32;

    logic        in_valid64 = 1'b0, in_ready64, kill64 = 1'b0, out_valid64, out_ready64 = 1'b0;
    logic [2:0]  op64 = '0;
    logic        s_32_64 = 1'b0;
    logic [63:0] rs1_64 = '0, rs2_64 = '0, result64;
    logic [4:0]  tag64 = '0, tag_out64;

    int vectors = 0;
    int miscompares = 0;

    muldiv_seq #(.XLEN(32), .BITS_PER_CYCLE(1), .TAG_W(5)) dut32 (
        .clock(clock), .reset(reset), .in_valid(in_valid32), .in_ready(in_ready32),
        .op(op32), .s_32(s_32_32), .rs1(rs1_32), .rs2(rs2_32), .tag_in(tag32),
        .kill(kill32), .out_valid(out_valid32), .out_ready(out_ready32),
        .result(result32), .tag_out(tag_out32)
    );

    muldiv_seq #(.XLEN(64), .BITS_PER_CYCLE(4), .TAG_W(5)) dut64 (
        .clock(clock), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .op(op64), .s_32(s_32_64), .rs1(rs1_64), .rs2(rs2_64), .tag_in(tag64),
        .kill(kill64), .out_valid(out_valid64), .out_ready(out_ready64),
        .result(result64), .tag_out(tag_out64)
    );

    // Clock generation.
    always #5 clock = ~clock;

    // Drives one op into dut32 and waits for out_valid. lat is the number of
    // edges after the accept edge (0 when the accept edge itself completes
    // the op), or -1 on timeout. When consume is set the result is taken.
    task automatic run32(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit consume,
                         output logic [31:0] r, output logic [4:0] tg, output int lat);
        int n;
        @(negedge clock);
        op32 = o; rs1_32 = a; rs2_32 = b; tag32 = t; in_valid32 = 1'b1;
        @(posedge clock); #1;
        in_valid32 = 1'b0;
        n = 0;
        while (!out_valid32 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        lat = out_valid32 ? n : -1;
        r   = result32;
        tg  = tag_out32;
        if (consume) begin
            @(negedge clock);
            out_ready32 = 1'b1;
            @(posedge clock); #1;
            out_ready32 = 1'b0;
        end
    endtask

    task automatic run64(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] r, output int lat);
        int n;
        @(negedge clock);
        op64 = o; s_32_64 = w; rs1_64 = a; rs2_64 = b; tag64 = 5'd3; in_valid64 = 1'b1;
        @(posedge clock); #1;
        in_valid64 = 1'b0;
        n = 0;
        while (!out_valid64 && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        lat = out_valid64 ? n : -1;
        r   = result64;
        @(negedge clock);
        out_ready64 = 1'b1;
        @(posedge clock); #1;
        out_ready64 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || result32 !== 32'h0 || tag_out32 !== 5'h0) begin
            $display("FAIL reset32: got rdy=%b vld=%b res=%h tag=%h expected 1 0 0 0",
                     in_ready32, out_valid32, result32, tag_out32);
            miscompares++;
        end
        vectors++;
        if (in_ready64 !== 1'b1 || out_valid64 !== 1'b0 || result64 !== 64'h0) begin
            $display("FAIL reset64: got rdy=%b vld=%b res=%h expected 1 0 0",
                     in_ready64, out_valid64, result64);
            miscompares++;
        end
        reset = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] r; logic [4:0] tg; int lat;
        logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] as  [4] = '{32'h7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], as[i], bs[i], 5'd11, 1'b1, r, tg, lat);
            vectors++;
            if (r !== exp[i]) begin
                $display("FAIL mul op%0d: got %h expected %h", ops[i], r, exp[i]);
                miscompares++;
            end
            vectors++;
            if (lat != 32) begin
                $display("FAIL mul_latency op%0d: got %0d expected 32", ops[i], lat);
                miscompares++;
            end
            vectors++;
            if (tg !== 5'd11) begin
                $display("FAIL mul_tag op%0d: got %0d expected 11", ops[i], tg);
                miscompares++;
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] r; logic [4:0] tg; int lat;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
        logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] exp [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], as[i], bs[i], 5'(i + 20), 1'b1, r, tg, lat);
            vectors++;
            if (r !== exp[i] || lat != 32 || tg !== 5'(i + 20)) begin
                $display("FAIL div op%0d: got res=%h lat=%0d tag=%0d expected res=%h lat=32 tag=%0d",
                         ops[i], r, lat, tg, exp[i], i + 20);
                miscompares++;
            end
        end
    endtask

    // Divide-by-zero and signed overflow finish on the accept edge.
    task automatic test_special();
        logic [31:0] r; logic [4:0] tg; int lat;
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
        for (int i = 0; i < 4; i++) begin
            run32(ops[i], as[i], bs[i], 5'd7, 1'b1, r, tg, lat);
            vectors++;
            if (r !== exp[i] || lat != 0) begin
                $display("FAIL special%0d: got res=%h lat=%0d expected res=%h lat=0",
                         i, r, lat, exp[i]);
                miscompares++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] r; logic [4:0] tg; int lat; int bad;
        run32(3'd5, 32'd100, 32'd7, 5'd9, 1'b0, r, tg, lat);
        vectors++;
        if (r !== 32'd14 || lat != 32) begin
            $display("FAIL bp_result: got res=%h lat=%0d expected 0000000e lat=32", r, lat);
            miscompares++;
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (out_valid32 !== 1'b1 || in_ready32 !== 1'b0 || result32 !== 32'd14 || tag_out32 !== 5'd9)
                bad++;
        end
        vectors++;
        if (bad != 0) begin
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
            miscompares++;
        end
        @(negedge clock);
        out_ready32 = 1'b1;
        @(posedge clock); #1;
        out_ready32 = 1'b0;
        vectors++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
            $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", out_valid32, in_ready32);
            miscompares++;
        end
    endtask

    task automatic test_kill();
        int seen;
        @(negedge clock);
        op32 = 3'd0; rs1_32 = 32'd3; rs2_32 = 32'd5; tag32 = 5'd2; in_valid32 = 1'b1;
        @(posedge clock); #1;
        in_valid32 = 1'b0;
        // Fifteen edges after accept leaves the counter at 17.
        repeat (15) @(posedge clock);
        @(negedge clock);
        kill32 = 1'b1;
        @(posedge clock); #1;
        kill32 = 1'b0;
        vectors++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin
            $display("FAIL kill_idle: got rdy=%b vld=%b expected 1 0", in_ready32, out_valid32);
            miscompares++;
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid32 === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            $display("FAIL kill_no_result: got %0d valid cycles expected 0", seen);
            miscompares++;
        end
        // kill together with in_valid in IDLE must not start an op.
        @(negedge clock);
        in_valid32 = 1'b1; kill32 = 1'b1;
        @(posedge clock); #1;
        in_valid32 = 1'b0; kill32 = 1'b0;
        vectors++;
        if (in_ready32 !== 1'b1) begin
            $display("FAIL kill_accept: got rdy=%b expected 1", in_ready32);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic [4:0] tg; int lat;
        @(negedge clock);
        op32 = 3'd4; rs1_32 = 32'd1000; rs2_32 = 32'd3; tag32 = 5'd30; in_valid32 = 1'b1;
        @(posedge clock); #1;
        in_valid32 = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0 || result32 !== 32'h0 || tag_out32 !== 5'h0) begin
            $display("FAIL reset_mid: got rdy=%b vld=%b res=%h tag=%h expected 1 0 0 0",
                     in_ready32, out_valid32, result32, tag_out32);
            miscompares++;
        end
        @(negedge clock);
        reset = 1'b1;
        run32(3'd4, 32'd1000, 32'd3, 5'd30, 1'b1, r, tg, lat);
        vectors++;
        if (r !== 32'd333 || lat != 32 || tg !== 5'd30) begin
            $display("FAIL after_reset: got res=%h lat=%0d tag=%0d expected 0000014d 32 30", r, lat, tg);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2; logic [4:0] t1, t2; int l1, l2;
        run32(3'd7, 32'd1234567, 32'd1000, 5'd1, 1'b1, r1, t1, l1);
        run32(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 1'b1, r2, t2, l2);
        vectors++;
        if (r1 !== 32'd567 || t1 !== 5'd1 || r2 !== 32'd1 || t2 !== 5'd2) begin
            $display("FAIL back_to_back: got %h/%0d %h/%0d expected 00000237/1 00000001/2",
                     r1, t1, r2, t2);
            miscompares++;
        end
    endtask

    task automatic test_w64();
        logic [63:0] r; int lat;
        logic [2:0]  ops [4] = '{3'd4, 3'd5, 3'd0, 3'd1};
        logic        ws  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [63:0] as  [4] = '{64'h1_80000000, 64'h1_80000000, 64'h1_00000000, 64'h7FFFFFFF};
        logic [63:0] bs  [4] = '{64'd2, 64'd2, 64'd3, 64'h7FFFFFFF};
        logic [63:0] exp [4] = '{64'hFFFFFFFF_C0000000, 64'h00000000_40000000,
                                 64'h00000003_00000000, 64'h0};
        int          lats [4] = '{8, 8, 16, 8};
        for (int i = 0; i < 4; i++) begin
            run64(ops[i], ws[i], as[i], bs[i], r, lat);
            vectors++;
            if (r !== exp[i] || lat != lats[i]) begin
                $display("FAIL w64_%0d: got res=%h lat=%0d expected res=%h lat=%0d",
                         i, r, lat, exp[i], lats[i]);
                miscompares++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_kill();
        test_reset_mid();
        test_back_to_back();
        test_w64();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
